serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; WIDTH SHALL be at least 2.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin an addition; SHALL be sampled only when busy=0.
REQ-005 Port: a  input  WIDTH  operand A; SHALL be captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  operand B; SHALL be captured on the accepted start edge.
REQ-007 Port: cin  input  1  carry-in; SHALL be captured on the accepted start edge.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-010 Port: sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL add bit-serially, LSB first, one bit per clock, using a single 1-bit full-adder slice (s = x^y^c, c' = xy|xc|yc) and a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, RUN and FIN; the reset state SHALL be IDLE.
REQ-014 IDLE: busy=0 and done=0; start=1 at an edge SHALL load the a/b shift registers, set carry=cin, clear the bit counter and enter RUN.
REQ-015 RUN: busy=1; each edge SHALL consume operand bit [0], shift both operand registers right, shift the result bit into the partial-sum register MSB, update carry and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the block SHALL copy the partial sum to sum, the final carry to cout, and enter FIN.
REQ-017 FIN: busy=0 and done=1 for exactly one cycle; the next edge SHALL return to IDLE, unless start=1, in which case a new operation SHALL load and RUN SHALL be entered directly.
REQ-018 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and busy SHALL be high in the cycles following edges k through k+WIDTH-1.
REQ-019 sum and cout SHALL change only on the final RUN edge and SHALL hold their last value otherwise, including through IDLE and during any subsequent RUN.
REQ-020 start while busy=1 SHALL be ignored; the in-flight operands and the in-flight carry SHALL NOT be disturbed.
REQ-021 Changes on a, b or cin after the accepted start edge SHALL NOT affect the result.
REQ-022 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.
REQ-023 The carry-out of the MSB SHALL appear only on cout, never in sum.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and operand/partial registers to 0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no result update; after release, the block SHALL accept start on the first edge.
REQ-026 After deassertion of rst_n, outputs SHALL remain at reset values until the first completed operation.

Verification
REQ-027 With WIDTH=8 and start at edge k: a=0x00, b=0x00, cin=0 -> done high after edge k+8, sum=0x00, cout=0; busy high for exactly 8 cycles.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0xA5, b=0x5A, cin=0 -> sum=0xFF, cout=0.
REQ-029 a=0x12, b=0x34 started, then start=1 with a=0xFF, b=0xFF mid-RUN and a/b changed afterwards -> single done pulse, sum=0x46, cout=0, no second operation.
REQ-030 Back-to-back: start held high from the first op -> second op accepted in the FIN cycle, done pulses 9 cycles apart, both results correct.
REQ-031 rst_n pulsed low at RUN cycle 4 of a=0x80, b=0x80 -> busy=0, sum=0x00, cout=0 immediately, no done; a following 0x80+0x80 op -> sum=0x00, cout=1.
REQ-032 WIDTH=2, all 32 combinations of a, b and cin checked against a+b+cin -> every {cout,sum} matches.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop produce one result
// bit per clock, LSB first; IDLE -> RUN (WIDTH edges) -> FIN (done pulse).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;
  logic             load;
  logic             last;

  // A new operation may load whenever busy is low: in IDLE and in FIN.
  assign load  = start && ((state == IDLE) || (state == FIN));
  assign last  = (state == RUN) && (cnt == CW'(WIDTH - 1));

  assign bit_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      RUN:     busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Results only move on the last RUN edge; they hold through IDLE and later runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      psum  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      psum  <= {bit_s, psum[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {bit_s, psum[WIDTH-1:1]};
        cout <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: cycle-level behavioural model for WIDTH=8 with
// directed and random operations, plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic [1:0] dbg_state;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
  logic [1:0] dbg_state2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .dbg_state(dbg_state)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: an accepted op completes WIDTH edges later
  int         m_rem  = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;
  logic [8:0] m_pend = '0;
  logic       m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else begin
      m_acc  = start && (m_rem == 0);
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          {m_cout, m_sum} = m_pend;
        end
      end
      if (m_acc) begin
        m_pend = 9'(a) + 9'(b) + 9'(cin);
        m_rem  = 8;
      end
    end
  end

  // scoreboard compare every cycle
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_rem > 0));
    check("done", 32'(done), 32'(m_done));
    check("sum",  32'(sum),  32'(m_sum));
    check("cout", 32'(cout), 32'(m_cout));
  end

  // driver tasks
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input string name);
    int busy_n;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd8);
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
    bit         got;
    logic [2:0] exp;
    exp = 3'(ta) + 3'(tb) + 3'(tc);
    @(posedge clk); #1;
    start2 = 1'b1; a2 = ta; b2 = tb; cin2 = tc;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = ~ta; b2 = ~tb; cin2 = ~tc;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    check("w2_done_seen", 32'(got), 32'd1);
    check($sformatf("w2_%0d+%0d+%0d", ta, tb, tc), 32'({cout2, sum2}), 32'(exp));
  endtask

  initial begin
    int         nd;
    int         t0;
    int         t1;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       c0;
    logic       c1;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c");
    do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "a5_5a");

    // start while busy is ignored; operand changes after acceptance are harmless
    @(posedge clk); #1;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF;
    repeat (3) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    nd = 0;
    s0 = '0; c0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin nd++; s0 = sum; c0 = cout; end
    end
    check("midrun_done_count", 32'(nd), 32'd1);
    check("midrun_sum", 32'(s0), 32'h46);
    check("midrun_cout", 32'(c0), 32'd0);

    // back-to-back: start held, second op loads in the FIN cycle
    @(posedge clk); #1;
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;
    a = 8'hC0; b = 8'h50; cin = 1'b1;
    nd = 0; t0 = 0; t1 = 0;
    s0 = '0; s1 = '0; c0 = 1'b0; c1 = 1'b0;
    for (int i = 0; i < 40 && nd < 2; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin
          t0 = cyc; s0 = sum; c0 = cout;
          @(posedge clk); #1;
          start = 1'b0;
        end else begin
          t1 = cyc; s1 = sum; c1 = cout;
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_spacing", 32'(t1 - t0), 32'd9);
    check("b2b_sum0", 32'(s0), 32'h30);
    check("b2b_cout0", 32'(c0), 32'd0);
    check("b2b_sum1", 32'(s1), 32'h11);
    check("b2b_cout1", 32'(c1), 32'd1);

    // reset in the middle of a run
    @(posedge clk); #1;
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_rst");

    // random traffic including starts while busy
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);

    // exhaustive WIDTH=2
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          op2(2'(x), 2'(y), 1'(c));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
